// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector between a show-ahead input FIFO and an output FIFO.
// Output lags input by WIDTH+1 pixels; border pixels are forced to zero from the output counters.
module sobel_stream #(
    parameter int WIDTH      = 720,
    parameter int HEIGHT     = 540,
    parameter int DATA_WIDTH = 8,
    parameter int BINARY     = 0,
    parameter int THRESHOLD  = 64
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_empty,
    input  logic [DATA_WIDTH-1:0] in_dout,
    output logic                  in_rd_en,
    input  logic                  out_full,
    output logic                  out_wr_en,
    output logic [DATA_WIDTH-1:0] out_din,
    output logic                  busy
);
    localparam int CW  = $clog2(WIDTH);
    localparam int RW  = $clog2(HEIGHT);
    localparam int GW  = DATA_WIDTH + 3;
    localparam int WIN = 2 * WIDTH + 2;
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [GW-1:0] SAT      = GW'((1 << DATA_WIDTH) - 1);
    localparam logic [GW-1:0] THR      = GW'(THRESHOLD);

    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

    state_t                r_state, w_state_next;
    logic [CW-1:0]         r_in_col, r_out_col;
    logic [RW-1:0]         r_in_row, r_out_row;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_win [WIN];
    logic                  w_pop, w_push, w_in_last, w_out_last, w_border;
    logic signed [GW-1:0]  w_gx, w_gy;
    logic [GW-1:0]         w_ax, w_ay, w_mag;
    logic [GW:0]           w_sum;
    logic [DATA_WIDTH-1:0] w_pixel;

    function automatic logic signed [GW-1:0] ext(input logic [DATA_WIDTH-1:0] p);
        return $signed({3'b000, p});
    endfunction

    assign w_in_last  = (r_in_row == ROW_LAST) && (r_in_col == COL_LAST);
    assign w_out_last = (r_out_row == ROW_LAST) && (r_out_col == COL_LAST);
    assign w_border   = (r_out_row == '0) || (r_out_row == ROW_LAST) ||
                        (r_out_col == '0) || (r_out_col == COL_LAST);

    // r_win[k] holds the pixel k+1 pops older than the FIFO head (in_dout).
    assign w_gx = (ext(r_win[2*WIDTH-1]) + (ext(r_win[WIDTH-1]) <<< 1) + ext(in_dout))
                - (ext(r_win[2*WIDTH+1]) + (ext(r_win[WIDTH+1]) <<< 1) + ext(r_win[1]));
    assign w_gy = (ext(r_win[1]) + (ext(r_win[0]) <<< 1) + ext(in_dout))
                - (ext(r_win[2*WIDTH+1]) + (ext(r_win[2*WIDTH]) <<< 1) + ext(r_win[2*WIDTH-1]));
    assign w_ax  = w_gx[GW-1] ? $unsigned(-w_gx) : $unsigned(w_gx);
    assign w_ay  = w_gy[GW-1] ? $unsigned(-w_gy) : $unsigned(w_gy);
    assign w_sum = {1'b0, w_ax} + {1'b0, w_ay};
    assign w_mag = w_sum[GW:1];

    always_comb begin
        w_pixel = '0;
        if (BINARY != 0) begin
            w_pixel = (w_mag >= THR) ? '1 : '0;
        end else if (w_mag > SAT) begin
            w_pixel = '1;
        end else begin
            w_pixel = w_mag[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_push       = 1'b0;
        case (r_state)
            FILL: begin
                w_pop = !in_empty;
                if (w_pop && (r_in_row == RW'(1)) && (r_in_col == '0)) w_state_next = RUN;
            end
            RUN: begin
                w_pop  = !in_empty && !out_full;
                w_push = w_pop;
                if (w_pop && w_in_last) w_state_next = FLUSH;
            end
            FLUSH: begin
                w_push = !out_full;
                if (w_push && w_out_last) w_state_next = FILL;
            end
            default: w_state_next = FILL;
        endcase
    end

    assign in_rd_en  = reset_n && w_pop;
    assign out_wr_en = reset_n && w_push;
    assign out_din   = (reset_n && (r_state == RUN) && !w_border) ? w_pixel : '0;
    assign busy      = r_busy;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= FILL;
            r_in_col  <= '0;
            r_in_row  <= '0;
            r_out_col <= '0;
            r_out_row <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_pop) begin
                if (r_in_col == COL_LAST) begin
                    r_in_col <= '0;
                    r_in_row <= (r_in_row == ROW_LAST) ? '0 : r_in_row + 1'b1;
                end else begin
                    r_in_col <= r_in_col + 1'b1;
                end
            end
            if (w_push) begin
                if (r_out_col == COL_LAST) begin
                    r_out_col <= '0;
                    r_out_row <= (r_out_row == ROW_LAST) ? '0 : r_out_row + 1'b1;
                end else begin
                    r_out_col <= r_out_col + 1'b1;
                end
            end
            if (w_pop && (r_state == FILL) && (r_in_row == '0) && (r_in_col == '0)) begin
                r_busy <= 1'b1;
            end else if (w_push && (r_state == FLUSH) && w_out_last) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Window contents need no reset: every output that could see stale data is a border pixel.
    always_ff @(posedge clock) begin
        if (w_pop) begin
            r_win[0] <= in_dout;
            for (int i = 1; i < WIN; i++) r_win[i] <= r_win[i-1];
        end
    end
endmodule

// File: doc/sobel_stream.md
Name: sobel_stream

Overview:
- Streaming 3x3 Sobel edge-detect stage for the image pipeline.
- Sits between the grayscale stage's output FIFO and the edge-image output FIFO.
- Consumes one pixel per FIFO pop in raster order and produces exactly WIDTH*HEIGHT output pixels per frame, one per output push.
- Successor to the fixed 8-bit, fixed-size stage: generalised in image size and pixel width, and adds a binary-threshold mode and back-to-back frames.

Parameters:
- WIDTH, 720, pixels per row (>=3)
- HEIGHT, 540, rows per frame (>=3)
- DATA_WIDTH, 8, bits per grayscale pixel
- BINARY, 0, 0 = magnitude output; 1 = thresholded output (all-ones or zero)
- THRESHOLD, 64, magnitude compare value used when BINARY=1

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- in_empty  in  1  input FIFO empty (show-ahead FIFO)
- in_dout  in  DATA_WIDTH  input FIFO head pixel, valid when in_empty=0
- in_rd_en  out  1  pop input FIFO
- out_full  in  1  output FIFO full
- out_wr_en  out  1  push output FIFO
- out_din  out  DATA_WIDTH  output pixel
- busy  out  1  high from the first pop of a frame until its last output push

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=FILL; input and output row/col counters=0; busy=0.
  - in_rd_en, out_wr_en and out_din are forced to 0 while reset_n is low.
  - Window shift-register contents are don't-care; border gating hides them.
- Window: shift register of 2*WIDTH+2 pixels plus in_dout as the newest tap. This gives the 3x3 neighbourhood of output pixel (r,c) when input pixel (r+1,c+1) is at the FIFO head. Output lags input by WIDTH+1 pixels.
- States:
  - FILL: in_rd_en = !in_empty. Each pop shifts in the pixel; no output. After WIDTH+1 pops -> RUN.
  - RUN: in_rd_en = out_wr_en = !in_empty && !out_full. out_din is combinational from the window and in_dout (same-cycle push). When the last input pixel (HEIGHT-1, WIDTH-1) is popped -> FLUSH.
  - FLUSH: in_rd_en=0; out_wr_en = !out_full; out_din=0. The remaining WIDTH+1 outputs are all border pixels. After WIDTH+1 pushes -> FILL and busy=0. The next frame starts with no idle cycle required.
- Border rule: output pixels with r=0, r=HEIGHT-1, c=0 or c=WIDTH-1 are 0, selected from the output counters.
- Arithmetic:
  - Gx = (p[r-1][c+1] + 2p[r][c+1] + p[r+1][c+1]) - (p[r-1][c-1] + 2p[r][c-1] + p[r+1][c-1]).
  - Gy = the same with rows and columns swapped (bottom minus top).
  - Gx and Gy are signed DATA_WIDTH+3 bits.
  - mag = (|Gx| + |Gy|) >> 1, saturated to 2^DATA_WIDTH-1.
  - BINARY=1: out_din = all-ones if mag >= THRESHOLD, else 0.
- Counters: output col wraps at WIDTH-1 into row+1; output row wraps at HEIGHT-1 to 0 at end of frame. Input counters behave the same way.
- Backpressure: while out_full=1 in RUN, no pop occurs, the window is held, and out_din is don't-care with out_wr_en=0. in_empty and out_full asserted together stall with no state change.
- Reset mid-frame: the partial frame is discarded and the next pixel popped is treated as (0,0). Counters never advance without a handshake.

Test Plan:
- WIDTH=HEIGHT=4, DATA_WIDTH=8, constant 90 image -> 16 outputs, all 0. The first push occurs on the cycle of the 6th pop; 5 flush pushes follow the last pop.
- 4x4 image with cols 0-1=0 and cols 2-3=200 -> outputs at (1,1),(1,2),(2,1),(2,2) = 255 (Gx=800, saturated); all border outputs 0.
- 4x4 image with rows 0-1=0 and rows 2-3=20 -> interior |Gy|=80, output 40; with BINARY=1 and THRESHOLD=40 the output is 255, and with THRESHOLD=41 it is 0.
- Random 8x6 image with random in_empty and out_full toggling -> output matches the software golden model exactly; no push while out_full=1 and no pop while in_empty=1; exactly 48 pushes.
- Two back-to-back 4x4 frames -> 32 outputs; the second frame matches golden; busy stays high across the boundary only while pushes are pending.
- Assert reset_n low after 7 pops, release, then stream a full 4x4 frame -> busy=0 and no push during reset; afterwards exactly 16 outputs matching golden for the new frame.
